// File: rtl/condlogic_pkg.sv
// Shared types and the condition-code evaluator for the ARM-style condition unit.
package condlogic_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    typedef enum logic {
        IT_IDLE   = 1'b0,
        IT_ACTIVE = 1'b1
    } it_state_e;

    function automatic logic cond_pass(input cond_e c, input logic [3:0] nzcv);
        logic n, z, cf, v;
        n  = nzcv[N_IDX];
        z  = nzcv[Z_IDX];
        cf = nzcv[C_IDX];
        v  = nzcv[V_IDX];
        case (c)
            EQ:      cond_pass = z;
            NE:      cond_pass = ~z;
            CS:      cond_pass = cf;
            CC:      cond_pass = ~cf;
            MI:      cond_pass = n;
            PL:      cond_pass = ~n;
            VS:      cond_pass = v;
            VC:      cond_pass = ~v;
            HI:      cond_pass = cf & ~z;
            LS:      cond_pass = ~cf | z;
            GE:      cond_pass = (n == v);
            LT:      cond_pass = (n != v);
            GT:      cond_pass = ~z & (n == v);
            LE:      cond_pass = z | (n != v);
            default: cond_pass = 1'b1;   // AL and NV both execute unconditionally
        endcase
    endfunction

endpackage

// File: rtl/condlogic_it_flaggroup_reg.sv
// One independently write-enabled slice of the architectural flag register.
module flaggroup_reg #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst)    q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/condlogic_it.sv
// Condition unit: flag register, condition gating of write enables and an
// If-Then sequencer that predicates up to MAXIT following instructions.
module condlogic_it
    import condlogic_pkg::*;
#(
    parameter int NGROUPS = 2,
    parameter int GROUPW  = 2,
    parameter int MAXIT   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            instr_valid,
    input  logic                            flush,
    input  logic                            PCS,
    input  logic                            RegW,
    input  logic                            MemW,
    input  logic [NGROUPS-1:0]              FlagW,
    input  logic [3:0]                      Cond,
    input  logic [NGROUPS*GROUPW-1:0]       ALUFlags,
    input  logic                            it_start,
    input  logic [3:0]                      it_cond,
    input  logic [$clog2(MAXIT+1)-1:0]      it_len,
    input  logic [MAXIT-1:0]                it_tmask,
    output logic                            PCSrc,
    output logic                            RegWrite,
    output logic                            MemWrite,
    output logic                            CondEx,
    output logic [NGROUPS*GROUPW-1:0]       Flags,
    output logic                            it_active,
    output logic [$clog2(MAXIT+1)-1:0]      it_remaining,
    output logic                            it_err
);

    localparam int ITW  = $clog2(MAXIT+1);
    localparam int IDXW = $clog2(MAXIT);

    it_state_e              state_q, state_n;
    logic [ITW-1:0]         rem_q, rem_n;
    logic [ITW-1:0]         len_q, len_n;
    logic [3:0]             itc_q, itc_n;
    logic [MAXIT-1:0]       tmask_q, tmask_n;
    logic                   err_q, err_n;

    logic                   act, it_go, illegal, else_used;
    logic [IDXW-1:0]        idx;
    logic [3:0]             eff_cond;
    logic                   wr_ok;

    // Flag storage, one register per group
    logic [NGROUPS-1:0][GROUPW-1:0] grp_q;

    for (genvar g = 0; g < NGROUPS; g++) begin : g_flag
        flaggroup_reg #(.W(GROUPW)) u_grp (
            .clk (clk),
            .rst (rst),
            .en  (FlagW[g] & CondEx & instr_valid & rst),
            .d   (ALUFlags[g*GROUPW +: GROUPW]),
            .q   (grp_q[g])
        );
    end

    assign Flags = grp_q;

    // Condition selection: inside a block the pattern bit picks then/else
    assign act      = (state_q == IT_ACTIVE);
    assign idx      = IDXW'(len_q - rem_q);
    assign eff_cond = !act          ? Cond :
                      tmask_q[idx]  ? itc_q : {itc_q[3:1], ~itc_q[0]};
    assign CondEx   = cond_pass(cond_e'(eff_cond), Flags[3:0]);

    assign it_go    = it_start & instr_valid;
    assign wr_ok    = CondEx & instr_valid & rst & ~it_go;
    assign PCSrc    = PCS  & wr_ok;
    assign RegWrite = RegW & wr_ok;
    assign MemWrite = MemW & wr_ok;

    always_comb begin
        else_used = 1'b0;
        for (int i = 0; i < MAXIT; i++)
            if ((ITW'(i) < it_len) && !it_tmask[i]) else_used = 1'b1;
    end

    // NV is never a legal block condition; AL only with an all-then pattern
    assign illegal = act
                   | (it_len == '0)
                   | (it_len > ITW'(MAXIT))
                   | ~it_tmask[0]
                   | (it_cond == NV)
                   | ((it_cond == AL) & else_used);

    always_comb begin
        state_n = state_q;
        rem_n   = rem_q;
        len_n   = len_q;
        itc_n   = itc_q;
        tmask_n = tmask_q;
        err_n   = err_q;
        if (flush) begin
            state_n = IT_IDLE;
            rem_n   = '0;
        end else if (instr_valid) begin
            if (it_start) begin
                if (illegal) begin
                    err_n = 1'b1;
                end else begin
                    state_n = IT_ACTIVE;
                    rem_n   = it_len;
                    len_n   = it_len;
                    itc_n   = it_cond;
                    tmask_n = it_tmask;
                end
            end else if (act) begin
                if (PCSrc && (rem_q > ITW'(1))) begin
                    state_n = IT_IDLE;
                    rem_n   = '0;
                    err_n   = 1'b1;
                end else begin
                    rem_n = rem_q - ITW'(1);
                    if (rem_q == ITW'(1)) state_n = IT_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IT_IDLE;
            rem_q   <= '0;
            len_q   <= '0;
            itc_q   <= '0;
            tmask_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            rem_q   <= rem_n;
            len_q   <= len_n;
            itc_q   <= itc_n;
            tmask_q <= tmask_n;
            err_q   <= err_n;
        end
    end

    assign it_active    = act;
    assign it_remaining = rem_q;
    assign it_err       = err_q;

endmodule

// File: tb/tb_condlogic_it.sv
// Directed bench for condlogic_it: flags, condition gating and IT sequencing.
module tb_condlogic_it;

    localparam int NGROUPS = 2;
    localparam int GROUPW  = 2;
    localparam int MAXIT   = 4;
    localparam int FLAGW   = NGROUPS*GROUPW;
    localparam int ITW     = $clog2(MAXIT+1);

    logic clk = 1'b0;
    logic rst, instr_valid, flush, PCS, RegW, MemW;
    logic [NGROUPS-1:0] FlagW;
    logic [3:0] Cond;
    logic [FLAGW-1:0] ALUFlags;
    logic it_start;
    logic [3:0] it_cond;
    logic [ITW-1:0] it_len;
    logic [MAXIT-1:0] it_tmask;
    logic PCSrc, RegWrite, MemWrite, CondEx;
    logic [FLAGW-1:0] Flags;
    logic it_active;
    logic [ITW-1:0] it_remaining;
    logic it_err;

    int n_checks = 0;
    int n_fail   = 0;

    condlogic_it #(.NGROUPS(NGROUPS), .GROUPW(GROUPW), .MAXIT(MAXIT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .flush(flush),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .Cond(Cond),
        .ALUFlags(ALUFlags), .it_start(it_start), .it_cond(it_cond),
        .it_len(it_len), .it_tmask(it_tmask), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
        .Flags(Flags), .it_active(it_active), .it_remaining(it_remaining),
        .it_err(it_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; combinational checks follow 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        instr_valid = 0; flush = 0; PCS = 0; RegW = 0; MemW = 0; FlagW = '0;
        Cond = 4'b1110; ALUFlags = '0; it_start = 0; it_cond = '0;
        it_len = '0; it_tmask = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 0;
        step();
        rst = 1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        idle_in();
        instr_valid = 1; FlagW = 2'b11; ALUFlags = f; Cond = 4'b1110;
        step();
        idle_in();
    endtask

    task automatic start_it(input logic [3:0] c, input logic [ITW-1:0] len,
                            input logic [MAXIT-1:0] tm);
        idle_in();
        instr_valid = 1; it_start = 1; it_cond = c; it_len = len; it_tmask = tm;
        step();
        idle_in();
    endtask

    task automatic test_reset();
        idle_in();
        rst = 0; instr_valid = 1; PCS = 1; RegW = 1; MemW = 1; FlagW = 2'b11;
        ALUFlags = 4'b1111;
        settle();
        n_checks++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin n_fail++; $display("FAIL reset_wen got %b expected 000", {PCSrc, RegWrite, MemWrite}); end
        step();
        n_checks++; if (Flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b expected 0000", Flags); end
        n_checks++; if (it_remaining !== 3'd0) begin n_fail++; $display("FAIL reset_rem got %0d expected 0", it_remaining); end
        n_checks++; if (it_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", it_err); end
        n_checks++; if (it_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b expected 0", it_active); end
        rst = 1;
        idle_in();
    endtask

    task automatic test_alu_flags();
        load_flags(4'b0100);
        n_checks++; if (Flags !== 4'b0100) begin n_fail++; $display("FAIL alu_flags got %b expected 0100", Flags); end
        instr_valid = 1; RegW = 1; Cond = 4'b0000;
        settle();
        n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL eq_regwrite got %b expected 1", RegWrite); end
        Cond = 4'b0001;
        settle();
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL ne_regwrite got %b expected 0", RegWrite); end
        idle_in();
    endtask

    task automatic test_cond_table();
        logic [3:0] fl [4]   = '{4'b1001, 4'b0010, 4'b0110, 4'b1000};
        logic [3:0] cd [4]   = '{4'b1010, 4'b1000, 4'b1001, 4'b1011};
        logic       exp_ [4] = '{1'b1,    1'b1,    1'b1,    1'b1};
        logic [3:0] cd2 [4]  = '{4'b1011, 4'b1001, 4'b1000, 4'b1100};
        logic       exp2 [4] = '{1'b0,    1'b0,    1'b0,    1'b0};
        for (int i = 0; i < 4; i++) begin
            load_flags(fl[i]);
            Cond = cd[i];
            settle();
            n_checks++; if (CondEx !== exp_[i]) begin n_fail++; $display("FAIL cond_pass[%0d] flags=%b cond=%b got %b expected %b", i, fl[i], cd[i], CondEx, exp_[i]); end
            Cond = cd2[i];
            settle();
            n_checks++; if (CondEx !== exp2[i]) begin n_fail++; $display("FAIL cond_fail[%0d] flags=%b cond=%b got %b expected %b", i, fl[i], cd2[i], CondEx, exp2[i]); end
        end
        idle_in();
    endtask

    task automatic test_partial_flags();
        load_flags(4'b1111);
        instr_valid = 1; FlagW = 2'b01; ALUFlags = 4'b0000; Cond = 4'b1110;
        step();
        n_checks++; if (Flags !== 4'b1100) begin n_fail++; $display("FAIL partial_write got %b expected 1100", Flags); end
        FlagW = 2'b10; Cond = 4'b0001;
        step();
        n_checks++; if (Flags !== 4'b1100) begin n_fail++; $display("FAIL failed_cond_write got %b expected 1100", Flags); end
        instr_valid = 0; FlagW = 2'b11; Cond = 4'b1110;
        step();
        n_checks++; if (Flags !== 4'b1100) begin n_fail++; $display("FAIL invalid_write got %b expected 1100", Flags); end
        idle_in();
    endtask

    task automatic test_it_block();
        logic exp_rw [3] = '{1'b1, 1'b0, 1'b1};
        load_flags(4'b0100);
        instr_valid = 1; it_start = 1; it_cond = 4'b0000; it_len = 3; it_tmask = 4'b0101;
        PCS = 1; RegW = 1; MemW = 1;
        settle();
        n_checks++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin n_fail++; $display("FAIL it_instr_wen got %b expected 000", {PCSrc, RegWrite, MemWrite}); end
        step();
        idle_in();
        n_checks++; if (it_active !== 1'b1 || it_remaining !== 3'd3) begin n_fail++; $display("FAIL it_start got act=%b rem=%0d expected act=1 rem=3", it_active, it_remaining); end
        step();
        n_checks++; if (it_remaining !== 3'd3) begin n_fail++; $display("FAIL it_hold got %0d expected 3", it_remaining); end
        for (int i = 0; i < 3; i++) begin
            instr_valid = 1; RegW = 1; Cond = 4'b0001;
            settle();
            n_checks++; if (RegWrite !== exp_rw[i]) begin n_fail++; $display("FAIL it_regwrite[%0d] got %b expected %b", i, RegWrite, exp_rw[i]); end
            step();
            n_checks++; if (it_remaining !== 3'(2 - i)) begin n_fail++; $display("FAIL it_rem[%0d] got %0d expected %0d", i, it_remaining, 2 - i); end
        end
        n_checks++; if (it_active !== 1'b0) begin n_fail++; $display("FAIL it_end_active got %b expected 0", it_active); end
        settle();
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL post_it_cond got %b expected 0", RegWrite); end
        idle_in();
    endtask

    task automatic test_branch_abort();
        do_reset();
        load_flags(4'b0100);
        start_it(4'b0000, 3'd4, 4'b1111);
        instr_valid = 1; RegW = 1;
        step();
        idle_in();
        instr_valid = 1; PCS = 1;
        settle();
        n_checks++; if (PCSrc !== 1'b1) begin n_fail++; $display("FAIL abort_pcsrc got %b expected 1", PCSrc); end
        step();
        idle_in();
        n_checks++; if ({it_active, it_remaining, it_err} !== {1'b0, 3'd0, 1'b1}) begin n_fail++; $display("FAIL abort_state got act=%b rem=%0d err=%b expected 0 0 1", it_active, it_remaining, it_err); end
        do_reset();
        load_flags(4'b0100);
        start_it(4'b0000, 3'd4, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            instr_valid = 1; RegW = 1;
            step();
        end
        idle_in();
        instr_valid = 1; PCS = 1;
        settle();
        n_checks++; if (PCSrc !== 1'b1) begin n_fail++; $display("FAIL last_branch_pcsrc got %b expected 1", PCSrc); end
        step();
        idle_in();
        n_checks++; if ({it_active, it_remaining, it_err} !== {1'b0, 3'd0, 1'b0}) begin n_fail++; $display("FAIL last_branch_state got act=%b rem=%0d err=%b expected 0 0 0", it_active, it_remaining, it_err); end
    endtask

    task automatic test_illegal_start();
        do_reset();
        start_it(4'b0000, 3'd0, 4'b0001);
        n_checks++; if ({it_active, it_err} !== 2'b01) begin n_fail++; $display("FAIL len0 got act=%b err=%b expected 0 1", it_active, it_err); end
        do_reset();
        start_it(4'b0000, 3'd2, 4'b0011);
        start_it(4'b0000, 3'd2, 4'b0011);
        n_checks++; if ({it_active, it_remaining, it_err} !== {1'b1, 3'd2, 1'b1}) begin n_fail++; $display("FAIL nested got act=%b rem=%0d err=%b expected 1 2 1", it_active, it_remaining, it_err); end
        do_reset();
        start_it(4'b1110, 3'd3, 4'b0011);
        n_checks++; if ({it_active, it_err} !== 2'b01) begin n_fail++; $display("FAIL al_else got act=%b err=%b expected 0 1", it_active, it_err); end
        do_reset();
        start_it(4'b0000, 3'd2, 4'b0010);
        n_checks++; if ({it_active, it_err} !== 2'b01) begin n_fail++; $display("FAIL tmask0 got act=%b err=%b expected 0 1", it_active, it_err); end
        do_reset();
        instr_valid = 0; it_start = 1; it_cond = 4'b0000; it_len = 3'd0; it_tmask = 4'b0001;
        step();
        idle_in();
        n_checks++; if ({it_active, it_remaining, it_err} !== {1'b0, 3'd0, 1'b0}) begin n_fail++; $display("FAIL no_valid got act=%b rem=%0d err=%b expected 0 0 0", it_active, it_remaining, it_err); end
    endtask

    task automatic test_flush();
        do_reset();
        load_flags(4'b0100);
        start_it(4'b0000, 3'd4, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            instr_valid = 1; RegW = 1;
            step();
        end
        n_checks++; if (it_remaining !== 3'd2) begin n_fail++; $display("FAIL pre_flush_rem got %0d expected 2", it_remaining); end
        instr_valid = 1; RegW = 1; flush = 1; FlagW = 2'b01; ALUFlags = 4'b0001;
        step();
        idle_in();
        n_checks++; if ({it_active, it_remaining} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL flush_state got act=%b rem=%0d expected 0 0", it_active, it_remaining); end
        n_checks++; if (Flags !== 4'b0101) begin n_fail++; $display("FAIL flush_flags got %b expected 0101", Flags); end
        instr_valid = 1; RegW = 1; Cond = 4'b0001;
        settle();
        n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL post_flush_ne got %b expected 0", RegWrite); end
        Cond = 4'b0000;
        settle();
        n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL post_flush_eq got %b expected 1", RegWrite); end
        idle_in();
    endtask

    task automatic test_reset_mid_block();
        load_flags(4'b0100);
        start_it(4'b0000, 3'd3, 4'b0111);
        instr_valid = 1; RegW = 1;
        step();
        rst = 0; instr_valid = 1; PCS = 1; RegW = 1; MemW = 1;
        settle();
        n_checks++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_wen got %b expected 000", {PCSrc, RegWrite, MemWrite}); end
        step();
        n_checks++; if ({Flags, it_remaining, it_active} !== {4'b0000, 3'd0, 1'b0}) begin n_fail++; $display("FAIL mid_reset_state got flags=%b rem=%0d act=%b expected 0000 0 0", Flags, it_remaining, it_active); end
        rst = 1;
        idle_in();
    endtask

    initial begin
        rst = 1;
        idle_in();
        step();
        test_reset();
        test_alu_flags();
        test_cond_table();
        test_partial_flags();
        test_it_block();
        test_branch_abort();
        test_illegal_start();
        test_flush();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
